// File: rtl/bp_me_burst_serializer.sv
// bp_me_burst_serializer
//
// Turns one complete CCE-side message (header + up to one cache block of
// payload) into a BP Burst stream: a single header beat on the header channel
// and zero or more data_width_p-bit beats on the data channel. The two output
// channels are independent ready&valid interfaces. Data beats may finish
// before the header does.
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   msg_header_i           opaque header to send
//   msg_size_i             log2 of payload bytes
//   msg_has_data_i         payload present
//   msg_data_i             payload, beat k at [k*data_width_p +: data_width_p]
//   msg_v_i / msg_ready_o  input handshake (ready only while idle)
//   header_o, header_v_o, header_ready_i   burst header channel
//   data_o, data_v_o, data_ready_i         burst data channel
//   data_last_o            final-beat flag (only with BP_ME_BURST_SERIALIZER_LAST_EN)
//
// Optional feature macro: BP_ME_BURST_SERIALIZER_LAST_EN adds data_last_o.

module bp_me_burst_serializer #(
  parameter int header_width_p = 64,
  parameter int block_width_p  = 512,
  parameter int data_width_p   = 64,
  parameter int size_width_p   = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] msg_header_i,
  input  logic [size_width_p-1:0]   msg_size_i,
  input  logic                      msg_has_data_i,
  input  logic [block_width_p-1:0]  msg_data_i,
  input  logic                      msg_v_i,
  output logic                      msg_ready_o,

  output logic [header_width_p-1:0] header_o,
  output logic                      header_v_o,
  input  logic                      header_ready_i,

  output logic [data_width_p-1:0]   data_o,
  output logic                      data_v_o,
  input  logic                      data_ready_i
`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
  ,
  output logic                      data_last_o
`endif
);

  localparam int max_beats_lp     = block_width_p / data_width_p;
  localparam int lg_dw_lp         = $clog2(data_width_p);
  localparam int lg_max_beats_lp  = $clog2(max_beats_lp);
  // One extra bit so the counter can hold max_beats_lp itself (the "done" value).
  localparam int cnt_width_lp     = lg_max_beats_lp + 1;
  localparam int idx_width_lp     = (max_beats_lp > 1) ? lg_max_beats_lp : 1;

  typedef enum logic {e_idle, e_send} state_e;

  state_e state_r, state_n;

  logic [header_width_p-1:0]                  header_r;
  logic [max_beats_lp-1:0][data_width_p-1:0]  data_r;
  logic [cnt_width_lp-1:0]                    beats_r;
  logic [cnt_width_lp-1:0]                    beat_cnt_r;
  logic                                       header_sent_r;
  logic [idx_width_lp-1:0]                    beat_idx;

  logic ready_int, accept, header_hs, data_hs;

  // Beat count for a message, done in the log domain so any size_width_p works
  // without a wide multiplier: payload bits = 2^(size+3).
  function automatic logic [cnt_width_lp-1:0] calc_beats(
    input logic [size_width_p-1:0] size,
    input logic                    has_data
  );
    int bits_lg;
    calc_beats = '0;
    bits_lg    = int'(size) + 3;
    if (!has_data)
      calc_beats = '0;
    else if (bits_lg <= lg_dw_lp)
      calc_beats = cnt_width_lp'(1);                // sub-beat sizes: one beat
    else if ((bits_lg - lg_dw_lp) >= lg_max_beats_lp)
      calc_beats = cnt_width_lp'(max_beats_lp);     // oversize: capped, no error
    else
      calc_beats = cnt_width_lp'(1) << (bits_lg - lg_dw_lp);
  endfunction

  // Beat select. After the last beat the counter reaches max_beats_lp and the
  // truncated index wraps to 0; data_v_o is low by then so the value is moot.
  if (max_beats_lp > 1) begin : g_idx
    assign beat_idx = beat_cnt_r[idx_width_lp-1:0];
  end else begin : g_idx1
    assign beat_idx = '0;
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n    = state_r;
    ready_int  = 1'b0;
    header_v_o = 1'b0;
    data_v_o   = 1'b0;
    accept     = 1'b0;
    header_hs  = 1'b0;
    data_hs    = 1'b0;
    case (state_r)
      e_idle: begin
        // reset_i gating keeps ready low while reset is held, not just after.
        ready_int = ~reset_i;
        accept    = msg_v_i & ready_int;
        if (accept) state_n = e_send;
      end
      e_send: begin
        header_v_o = ~header_sent_r;
        data_v_o   = (beat_cnt_r < beats_r);
        header_hs  = header_v_o & header_ready_i;
        data_hs    = data_v_o & data_ready_i;
        // Done when both channels are finished, counting this cycle's handshakes.
        if ((header_sent_r | header_hs) &&
            ((beat_cnt_r + cnt_width_lp'(data_hs)) == beats_r))
          state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign msg_ready_o = ready_int;

  // Message capture and progress tracking
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      header_r      <= '0;
      data_r        <= '0;
      beats_r       <= '0;
      beat_cnt_r    <= '0;
      header_sent_r <= 1'b0;
    end else if (accept) begin
      header_r      <= msg_header_i;
      data_r        <= msg_data_i;
      beats_r       <= calc_beats(msg_size_i, msg_has_data_i);
      beat_cnt_r    <= '0;
      header_sent_r <= 1'b0;
    end else begin
      if (header_hs) header_sent_r <= 1'b1;
      if (data_hs)   beat_cnt_r    <= beat_cnt_r + cnt_width_lp'(1);
    end
  end

  // Outputs come straight from registers, so they are stable during stalls
  // and read 0 while reset is asserted.
  assign header_o = header_r;
  assign data_o   = data_r[beat_idx];

`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
  assign data_last_o = data_v_o & (beat_cnt_r == (beats_r - cnt_width_lp'(1)));
`endif

endmodule

// File: tb/tb_bp_me_burst_serializer.sv
// Self-checking bench for bp_me_burst_serializer (default parameters).
// A reference model derives the expected beat list of each message from the
// payload size rules; a negedge monitor records every handshake and checks
// that stalled channels hold their values.

module tb_bp_me_burst_serializer;

  localparam int HW = 64;
  localparam int BW = 512;
  localparam int DW = 64;
  localparam int SW = 3;
  localparam int NB = BW / DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [HW-1:0] msg_header;
  logic [SW-1:0] msg_size;
  logic          msg_has_data;
  logic [BW-1:0] msg_data;
  logic          msg_v;
  logic          msg_ready;
  logic [HW-1:0] header;
  logic          header_v;
  logic          header_ready;
  logic [DW-1:0] data;
  logic          data_v;
  logic          data_ready;
`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
  logic          data_last;
`endif

  bp_me_burst_serializer #(
    .header_width_p(HW), .block_width_p(BW), .data_width_p(DW), .size_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .msg_header_i(msg_header), .msg_size_i(msg_size), .msg_has_data_i(msg_has_data),
    .msg_data_i(msg_data), .msg_v_i(msg_v), .msg_ready_o(msg_ready),
    .header_o(header), .header_v_o(header_v), .header_ready_i(header_ready),
    .data_o(data), .data_v_o(data_v), .data_ready_i(data_ready)
`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
    , .data_last_o(data_last)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observations and expectations
  logic [DW-1:0] obs_data[$];
  int            obs_dcyc[$];
  logic [HW-1:0] obs_hdr[$];
  int            obs_hcyc[$];
  bit            obs_last[$];
  logic [DW-1:0] exp_data[$];
  logic [HW-1:0] exp_hdr;

  bit            h_stall = 0, d_stall = 0;
  logic [HW-1:0] h_prev;
  logic [DW-1:0] d_prev;

  // Monitor: record handshakes, check that stalled channels hold
  always @(negedge clk) begin
    if (rst) begin
      h_stall = 0;
      d_stall = 0;
    end else begin
      if (h_stall) begin
        checks++;
        if (header_v !== 1'b1 || header !== h_prev) begin
          errors++;
          $display("FAIL header_hold: v=%b hdr=%h required v=1 hdr=%h", header_v, header, h_prev);
        end
      end
      if (d_stall) begin
        checks++;
        if (data_v !== 1'b1 || data !== d_prev) begin
          errors++;
          $display("FAIL data_hold: v=%b data=%h required v=1 data=%h", data_v, data, d_prev);
        end
      end
      if (header_v && header_ready) begin
        obs_hdr.push_back(header);
        obs_hcyc.push_back(cyc);
      end
      if (data_v && data_ready) begin
        obs_data.push_back(data);
        obs_dcyc.push_back(cyc);
`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
        obs_last.push_back(data_last);
`endif
      end
      h_stall = header_v && !header_ready;
      h_prev  = header;
      d_stall = data_v && !data_ready;
      d_prev  = data;
    end
  end

  // Reference model: beats from payload bytes, floor 1, cap at block
  function automatic int model_beats(input int size, input bit has);
    int n;
    if (!has) return 0;
    n = ((1 << size) * 8) / DW;
    if (n < 1)  n = 1;
    if (n > NB) n = NB;
    return n;
  endfunction

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] d;
    for (int w = 0; w < BW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Present one message and wait for its acceptance; returns the cycle stamp
  // of the first post-accept cycle as seen by the monitor.
  task automatic send_msg(input logic [HW-1:0] hdr, input int size, input bit has,
                          input logic [BW-1:0] d, output int acc);
    int w;
    int n;
    obs_data.delete(); obs_dcyc.delete(); obs_hdr.delete(); obs_hcyc.delete(); obs_last.delete();
    exp_data.delete();
    exp_hdr = hdr;
    n = model_beats(size, has);
    for (int k = 0; k < n; k++) exp_data.push_back(d[k*DW +: DW]);
    w = 0;
    while (!msg_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!msg_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: msg_ready=%b required 1", msg_ready);
    end
    msg_header   = hdr;
    msg_size     = SW'(size);
    msg_has_data = has;
    msg_data     = d;
    msg_v        = 1'b1;
    @(posedge clk);
    #1;
    msg_v = 1'b0;
    msg_header = '1; msg_data = '1; msg_size = '1; msg_has_data = 1'b1;
    acc = cyc;
  endtask

  // Drive readies per cycle until msg_ready returns; ncyc = cycles from the
  // accept edge to the first cycle with msg_ready high.
  // mode 0: all high; 1: random; 2: header low for 'hold' cycles; 3: data 1,0,1,0
  task automatic run_until_idle(input int mode, input int hold, output int ncyc);
    int i;
    i = 1;
    ncyc = -1;
    while (i <= 200) begin
      case (mode)
        0: begin header_ready = 1; data_ready = 1; end
        1: begin header_ready = 1'($urandom_range(0, 1)); data_ready = 1'($urandom_range(0, 1)); end
        2: begin header_ready = (i > hold); data_ready = 1; end
        default: begin header_ready = 1; data_ready = (i % 2 == 1); end
      endcase
      @(negedge clk);
      if (msg_ready) begin
        ncyc = i;
        break;
      end
      @(posedge clk);
      #1;
      i++;
    end
    if (ncyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: msg_ready never returned within %0d cycles", 200);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    msg_v = 1; msg_header = '1; msg_size = 3'd6; msg_has_data = 1; msg_data = '1;
    header_ready = 1; data_ready = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({msg_ready, header_v, data_v} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: ready/hv/dv=%b required 000", {msg_ready, header_v, data_v});
    end
    checks++;
    if (header !== '0 || data !== '0) begin
      errors++;
      $display("FAIL reset_data: hdr=%h data=%h required 0 0", header, data);
    end
    msg_v = 0;
    @(posedge clk); #2;
    rst = 0;
    @(negedge clk);
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", msg_ready);
    end
  endtask

  task automatic test_full_block();
    logic [BW-1:0] d;
    int acc, ncyc;
    for (int k = 0; k < NB; k++) d[k*DW +: DW] = DW'(64'h1000 + k);
    send_msg(64'hABCD_0000_1234_5678, 6, 1, d, acc);
    run_until_idle(0, 0, ncyc);
    checks++;
    if (ncyc != 9) begin
      errors++; $display("FAIL full_ready_again: got %0d cycles required 9", ncyc);
    end
    checks++;
    if (obs_hdr.size() != 1 || obs_hcyc[0] != acc || obs_hdr[0] !== exp_hdr) begin
      errors++; $display("FAIL full_header: count=%0d required 1 at cycle after accept, hdr %h", obs_hdr.size(), exp_hdr);
    end
    checks++;
    if (obs_data.size() != NB) begin
      errors++; $display("FAIL full_beat_count: got %0d required %0d", obs_data.size(), NB);
    end
    for (int k = 0; k < NB && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== DW'(64'h1000 + k) || obs_dcyc[k] != acc + k) begin
        errors++;
        $display("FAIL full_beat%0d: got %h at +%0d required %h at +%0d", k, obs_data[k], obs_dcyc[k] - acc, DW'(64'h1000 + k), k);
      end
`ifdef BP_ME_BURST_SERIALIZER_LAST_EN
      checks++;
      if (obs_last[k] !== (k == NB - 1)) begin
        errors++; $display("FAIL full_last%0d: got %b required %b", k, obs_last[k], (k == NB - 1));
      end
`endif
    end
  endtask

  task automatic test_small_sizes();
    int sizes[4] = '{3, 2, 0, 7};
    int acc, ncyc, n;
    logic [BW-1:0] d;
    for (int t = 0; t < 4; t++) begin
      d = rand_block();
      send_msg(HW'($urandom), sizes[t], 1, d, acc);
      run_until_idle(0, 0, ncyc);
      n = model_beats(sizes[t], 1);
      checks++;
      if (obs_data.size() != n || ncyc != n + 1) begin
        errors++;
        $display("FAIL small_size%0d_count: got %0d beats/%0d cycles required %0d/%0d", sizes[t], obs_data.size(), ncyc, n, n + 1);
      end
      for (int k = 0; k < n && k < obs_data.size(); k++) begin
        checks++;
        if (obs_data[k] !== d[k*DW +: DW]) begin
          errors++; $display("FAIL small_size%0d_beat%0d: got %h required %h", sizes[t], k, obs_data[k], d[k*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_header_only();
    int acc, ncyc;
    for (int t = 0; t < 3; t++) begin
      send_msg(HW'({$urandom, $urandom}), $urandom_range(0, 7), 0, rand_block(), acc);
      run_until_idle(0, 0, ncyc);
      checks++;
      if (obs_data.size() != 0 || ncyc != 2) begin
        errors++; $display("FAIL hdr_only: got %0d beats/%0d cycles required 0/2", obs_data.size(), ncyc);
      end
      checks++;
      if (obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr) begin
        errors++; $display("FAIL hdr_only_value: count=%0d required 1 of %h", obs_hdr.size(), exp_hdr);
      end
    end
  endtask

  task automatic test_header_backpressure();
    int holds[2] = '{5, 10};
    int acc, ncyc;
    for (int t = 0; t < 2; t++) begin
      send_msg(HW'({$urandom, $urandom}), 6, 1, rand_block(), acc);
      run_until_idle(2, holds[t], ncyc);
      checks++;
      if (ncyc != ((holds[t] + 1 > NB) ? holds[t] + 2 : NB + 1)) begin
        errors++; $display("FAIL hbp%0d_done: got %0d cycles required %0d", holds[t], ncyc, (holds[t] + 1 > NB) ? holds[t] + 2 : NB + 1);
      end
      checks++;
      if (obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr || obs_hcyc[0] != acc + holds[t]) begin
        errors++; $display("FAIL hbp%0d_header: count=%0d required 1 of %h", holds[t], obs_hdr.size(), exp_hdr);
      end
      checks++;
      if (obs_data.size() != NB) begin
        errors++; $display("FAIL hbp%0d_beats: got %0d required %0d", holds[t], obs_data.size(), NB);
      end
      for (int k = 0; k < NB && k < obs_data.size(); k++) begin
        checks++;
        if (obs_data[k] !== exp_data[k] || obs_dcyc[k] != acc + k) begin
          errors++; $display("FAIL hbp%0d_beat%0d: got %h at +%0d required %h at +%0d", holds[t], k, obs_data[k], obs_dcyc[k] - acc, exp_data[k], k);
        end
      end
    end
  endtask

  task automatic test_data_backpressure();
    int acc, ncyc;
    send_msg(HW'($urandom), 6, 1, rand_block(), acc);
    run_until_idle(3, 0, ncyc);
    checks++;
    if (ncyc != 2 * NB) begin
      errors++; $display("FAIL dbp_done: got %0d cycles required %0d", ncyc, 2 * NB);
    end
    checks++;
    if (obs_data.size() != NB) begin
      errors++; $display("FAIL dbp_beats: got %0d required %0d", obs_data.size(), NB);
    end
    for (int k = 0; k < NB && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL dbp_beat%0d: got %h required %h", k, obs_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, ncyc, n, sz;
    bit has;
    for (int t = 0; t < 8; t++) begin
      sz  = $urandom_range(0, 7);
      has = 1'($urandom_range(0, 3) != 0);
      send_msg(HW'({$urandom, $urandom}), sz, has, rand_block(), acc);
      run_until_idle(0, 0, ncyc);
      n = model_beats(sz, has);
      checks++;
      if (ncyc != ((n < 1) ? 1 : n) + 1) begin
        errors++; $display("FAIL b2b%0d_cycles: got %0d required %0d", t, ncyc, ((n < 1) ? 1 : n) + 1);
      end
      checks++;
      if (obs_data != exp_data || obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr) begin
        errors++; $display("FAIL b2b%0d_content: %0d beats/%0d hdrs required %0d/1", t, obs_data.size(), obs_hdr.size(), n);
      end
    end
  endtask

  task automatic test_random();
    int acc, ncyc, sz;
    bit has;
    for (int t = 0; t < 30; t++) begin
      sz  = $urandom_range(0, 7);
      has = 1'($urandom_range(0, 3) != 0);
      send_msg(HW'({$urandom, $urandom}), sz, has, rand_block(), acc);
      run_until_idle(1, 0, ncyc);
      checks++;
      if (obs_data != exp_data) begin
        errors++; $display("FAIL rand%0d_data: got %0d beats required %0d (size %0d has %0b)", t, obs_data.size(), exp_data.size(), sz, has);
      end
      checks++;
      if (obs_hdr.size() != 1 || obs_hdr[0] !== exp_hdr) begin
        errors++; $display("FAIL rand%0d_header: count=%0d required 1 of %h", t, obs_hdr.size(), exp_hdr);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int acc, ncyc;
    logic [BW-1:0] d;
    d = rand_block();
    send_msg(HW'($urandom), 6, 1, d, acc);
    header_ready = 1; data_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({msg_ready, header_v, data_v} !== 3'b000 || data !== '0) begin
      errors++; $display("FAIL mid_reset_drop: ready/hv/dv=%b data=%h required 000 and 0", {msg_ready, header_v, data_v}, data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (msg_ready !== 1'b1 || obs_data.size() != 3) begin
      errors++; $display("FAIL mid_reset_release: ready=%b beats=%0d required 1 and 3", msg_ready, obs_data.size());
    end
    for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== d[k*DW +: DW]) begin
        errors++; $display("FAIL mid_reset_beat%0d: got %h required %h", k, obs_data[k], d[k*DW +: DW]);
      end
    end
    d = rand_block();
    send_msg(HW'($urandom), 3, 1, d, acc);
    run_until_idle(0, 0, ncyc);
    checks++;
    if (obs_data.size() != 1 || ncyc != 2 || obs_hdr.size() != 1) begin
      errors++; $display("FAIL post_reset_msg: %0d beats/%0d cycles required 1/2", obs_data.size(), ncyc);
    end else begin
      checks++;
      if (obs_data[0] !== d[DW-1:0]) begin
        errors++; $display("FAIL post_reset_beat: got %h required %h", obs_data[0], d[DW-1:0]);
      end
    end
  endtask

  initial begin
    rst = 1; msg_v = 0; msg_header = '0; msg_size = '0; msg_has_data = 0; msg_data = '0;
    header_ready = 0; data_ready = 0;
    test_reset();
    test_full_block();
    test_small_sizes();
    test_header_only();
    test_header_backpressure();
    test_data_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
